// File: rtl/servile_timer.sv
// Machine timer: 64-bit mtime/mtimecmp with optional 8-bit prescaler, MTIME_HI read shadow and level IRQ on a Wishbone slave.
// Latency: ack and read data are registered one cycle after stb; the IRQ is registered one cycle behind mtime/mtimecmp.
// Backpressure: none; every request is acked on the next edge, and a held stb is acked on alternate cycles.
// Ports: i_clk / i_rst_n clock and asynchronous active-low reset; i_wb_adr/dat/sel/we/stb Wishbone request
//        (adr is the word address); o_wb_rdt / o_wb_ack registered read data and single-cycle ack;
//        o_timer_irq level interrupt to the core.
module servile_timer #(
    parameter logic [63:0] reset_cmp      = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter bit          with_prescaler = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

    localparam logic [2:0] ADR_MTIME_LO = 3'd0;
    localparam logic [2:0] ADR_MTIME_HI = 3'd1;
    localparam logic [2:0] ADR_CMP_LO   = 3'd2;
    localparam logic [2:0] ADR_CMP_HI   = 3'd3;
    localparam logic [2:0] ADR_CTRL     = 3'd4;
    localparam logic [2:0] ADR_STATUS   = 3'd5;

    logic [63:0] mtime;
    logic [63:0] mtime_nxt;
    logic [63:0] mtime_inc;
    logic [63:0] mtimecmp;
    logic [31:0] shadow;
    logic        en;
    logic [7:0]  div;
    logic [7:0]  pcnt;

    logic        access;
    logic        wr;
    logic        rd;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        wr_ctrl;
    logic        tick;
    logic        cmp_hit;
    logic [31:0] ctrl_word;
    logic [31:0] ctrl_wr;
    logic [31:0] rd_mux;

    // Byte-lane merge for partial writes.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] res;
        res = old;
        for (int k = 0; k < 4; k++) begin
            if (sel[k]) res[8*k +: 8] = dat[8*k +: 8];
        end
        return res;
    endfunction

    // A new access is only recognised while ack is low, so each request is seen exactly once.
    assign access      = i_wb_stb & ~o_wb_ack;
    assign wr          = access & i_wb_we;
    assign rd          = access & ~i_wb_we;
    assign wr_mtime_lo = wr && (i_wb_adr == ADR_MTIME_LO);
    assign wr_mtime_hi = wr && (i_wb_adr == ADR_MTIME_HI);
    assign wr_cmp_lo   = wr && (i_wb_adr == ADR_CMP_LO);
    assign wr_cmp_hi   = wr && (i_wb_adr == ADR_CMP_HI);
    assign wr_ctrl     = wr && (i_wb_adr == ADR_CTRL);

    assign tick      = en && (!with_prescaler || (pcnt == div));
    assign cmp_hit   = (mtime >= mtimecmp);
    assign ctrl_word = {16'h0000, div, 7'b0000000, en};
    assign ctrl_wr   = merge(ctrl_word, i_wb_dat, i_wb_sel);

    // A bus write to a half wins over the increment; when the low half is written,
    // the carry into the high half is dropped for that cycle.
    always_comb begin
        mtime_inc = mtime + 64'd1;
        mtime_nxt = mtime;
        if (tick) mtime_nxt[31:0] = mtime_inc[31:0];
        if (tick && !wr_mtime_lo) mtime_nxt[63:32] = mtime_inc[63:32];
        if (wr_mtime_lo) mtime_nxt[31:0] = merge(mtime[31:0], i_wb_dat, i_wb_sel);
        if (wr_mtime_hi) mtime_nxt[63:32] = merge(mtime[63:32], i_wb_dat, i_wb_sel);
    end

    always_comb begin
        rd_mux = 32'h0000_0000;
        case (i_wb_adr)
            ADR_MTIME_LO: rd_mux = mtime[31:0];
            ADR_MTIME_HI: rd_mux = shadow;
            ADR_CMP_LO:   rd_mux = mtimecmp[31:0];
            ADR_CMP_HI:   rd_mux = mtimecmp[63:32];
            ADR_CTRL:     rd_mux = ctrl_word;
            ADR_STATUS:   rd_mux = {31'h0, cmp_hit};
            default:      rd_mux = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime       <= 64'h0;
            shadow      <= 32'h0;
            mtimecmp    <= reset_cmp;
            en          <= 1'b0;
            div         <= 8'h00;
            pcnt        <= 8'h00;
            o_wb_ack    <= 1'b0;
            o_wb_rdt    <= 32'h0;
            o_timer_irq <= 1'b0;
        end else begin
            o_wb_ack <= access;
            o_wb_rdt <= rd ? rd_mux : 32'h0;

            // Latch the high word together with the low-word read so MTIME_HI
            // returns a value coherent with the low word just returned.
            if (rd && (i_wb_adr == ADR_MTIME_LO)) shadow <= mtime[63:32];

            mtime <= mtime_nxt;

            if (wr_cmp_lo) mtimecmp[31:0]  <= merge(mtimecmp[31:0], i_wb_dat, i_wb_sel);
            if (wr_cmp_hi) mtimecmp[63:32] <= merge(mtimecmp[63:32], i_wb_dat, i_wb_sel);

            if (wr_ctrl) begin
                en  <= ctrl_wr[0];
                div <= with_prescaler ? ctrl_wr[15:8] : 8'h00;
            end

            // A CTRL write restarts the prescale phase.
            if (wr_ctrl) begin
                pcnt <= 8'h00;
            end else if (en) begin
                pcnt <= (pcnt == div) ? 8'h00 : pcnt + 8'd1;
            end

            o_timer_irq <= en & cmp_hit;
        end
    end

endmodule

// File: tb/tb_servile_timer.sv
`timescale 1ns/1ps
module tb_servile_timer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [2:0]  i_wb_adr = 3'd0;
    logic [31:0] i_wb_dat = 32'h0;
    logic [3:0]  i_wb_sel = 4'h0;
    logic        i_wb_we = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_timer_irq;

    servile_timer dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_wb_adr    (i_wb_adr),
        .i_wb_dat    (i_wb_dat),
        .i_wb_sel    (i_wb_sel),
        .i_wb_we     (i_wb_we),
        .i_wb_stb    (i_wb_stb),
        .o_wb_rdt    (o_wb_rdt),
        .o_wb_ack    (o_wb_ack),
        .o_timer_irq (o_timer_irq)
    );

    always #5 i_clk = ~i_clk;

    // Rising-edge counter; at a falling edge the next access edge is cyc+1.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    int   last_edge;
    logic irq_at_ack;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge one cycle after the ack cycle.
    task automatic bus(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdata);
        int n;
        n = 0;
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = sel;
        i_wb_stb = 1'b1;
        do begin
            @(negedge i_clk);
            n++;
        end while (o_wb_ack !== 1'b1 && n < 4);
        check_bit("ack_seen", o_wb_ack, 1'b1);
        rdata      = o_wb_rdt;
        irq_at_ack = o_timer_irq;
        i_wb_stb   = 1'b0;
        i_wb_we    = 1'b0;
        @(negedge i_clk);
        check_bit("ack_single_cycle", o_wb_ack, 1'b0);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] rdata;
        last_edge = cyc + 1;
        bus(1'b1, adr, dat, sel, rdata);
        check_word("wr_rdt_zero", rdata, 32'h0);
    endtask

    task automatic rd_chk(input logic [2:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] rdata;
        sb_t         item;
        item.tag = tag;
        item.exp = exp;
        sb_q.push_back(item);
        bus(1'b0, adr, 32'h0, 4'h0, rdata);
        item = sb_q.pop_front();
        check_word(item.tag, rdata, item.exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e0, e1, e2, e3, e4, e5, m2;
        logic [63:0] full;

        // Reset state
        #12;
        check_bit("rst_ack", o_wb_ack, 1'b0);
        check_word("rst_rdt", o_wb_rdt, 32'h0);
        check_bit("rst_irq", o_timer_irq, 1'b0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        rd_chk(3'd2, 32'hFFFF_FFFF, "cmp_lo_reset");
        rd_chk(3'd3, 32'hFFFF_FFFF, "cmp_hi_reset");
        rd_chk(3'd4, 32'h0,         "ctrl_reset");
        rd_chk(3'd5, 32'h0,         "status_reset");
        rd_chk(3'd0, 32'h0,         "mtime_lo_reset");
        wr(3'd7, 32'h1234_5678);
        rd_chk(3'd7, 32'h0,         "adr7_reads_zero");

        // Enable, DIV=0: one tick per edge after the enabling edge
        wr(3'd4, 32'h0000_0001);
        e0 = last_edge;
        repeat (10) @(negedge i_clk);
        rd_chk(3'd0, 32'(cyc - e0), "mtime_free_run");

        // DIV=3: one tick every 4 edges, restarted by a CTRL rewrite
        wr(3'd4, 32'h0);
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h0000_0301);
        e1 = last_edge;
        repeat (7) @(negedge i_clk);
        rd_chk(3'd0, 32'((cyc - e1) / 4), "mtime_div3");
        rd_chk(3'd4, 32'h0000_0301, "ctrl_readback");
        wr(3'd4, 32'h0000_0301);
        e2 = last_edge;
        m2 = (e2 - e1) / 4;
        repeat (5) @(negedge i_clk);
        rd_chk(3'd0, 32'(m2 + (cyc - e2) / 4), "mtime_div3_restart");

        // Carry from low to high word
        wr(3'd4, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd0, 32'hFFFF_FFFE);
        wr(3'd4, 32'h0000_0001);
        e3 = last_edge;
        @(negedge i_clk);
        full = 64'h0000_0000_FFFF_FFFE + 64'(cyc - e3);
        rd_chk(3'd0, full[31:0],  "carry_lo");
        rd_chk(3'd1, full[63:32], "carry_hi");

        // 64-bit wrap from all-ones
        wr(3'd4, 32'h0);
        wr(3'd0, 32'hFFFF_FFFF);
        wr(3'd1, 32'hFFFF_FFFF);
        wr(3'd4, 32'h0000_0001);
        e4 = last_edge;
        full = 64'hFFFF_FFFF_FFFF_FFFF + 64'(cyc - e4);
        rd_chk(3'd0, full[31:0],  "wrap_lo");
        rd_chk(3'd1, full[63:32], "wrap_hi");

        // Shadow: MTIME_HI returns the value latched by the MTIME_LO read
        wr(3'd4, 32'h0);
        wr(3'd1, 32'h0000_0005);
        wr(3'd0, 32'h0000_0010);
        rd_chk(3'd0, 32'h0000_0010, "shadow_lo");
        wr(3'd1, 32'h0000_0007);
        rd_chk(3'd1, 32'h0000_0005, "shadow_hi_latched");

        // Interrupt rise and fall
        wr(3'd0, 32'h0);
        wr(3'd1, 32'h0);
        wr(3'd3, 32'h0);
        wr(3'd2, 32'd20);
        wr(3'd4, 32'h0000_0001);
        e5 = last_edge;
        while (cyc < e5 + 20) @(negedge i_clk);
        check_bit("irq_before_match", o_timer_irq, 1'b0);
        @(negedge i_clk);
        check_bit("irq_after_match", o_timer_irq, 1'b1);
        rd_chk(3'd5, 32'h0000_0001, "status_hit");
        wr(3'd2, 32'hFFFF_FFFF);
        check_bit("irq_on_cmp_wr_ack", irq_at_ack, 1'b1);
        check_bit("irq_fall_after_cmp", o_timer_irq, 1'b0);
        wr(3'd2, 32'd20);
        check_bit("irq_rearm", o_timer_irq, 1'b1);
        wr(3'd4, 32'h0);
        check_bit("irq_en_clear", o_timer_irq, 1'b0);

        // Byte-lane write from reset value
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        wr(3'd2, 32'hAABB_CCDD, 4'b0010);
        rd_chk(3'd2, 32'hFFFF_CCFF, "byte_lane_write");

        // Reset in the middle of an acked access
        wr(3'd2, 32'h0);
        wr(3'd3, 32'h0);
        wr(3'd4, 32'h0000_0001);
        repeat (2) @(negedge i_clk);
        check_bit("irq_pre_reset", o_timer_irq, 1'b1);
        i_wb_adr = 3'd4;
        i_wb_we  = 1'b0;
        i_wb_stb = 1'b1;
        #6;
        check_bit("ack_pre_reset", o_wb_ack, 1'b1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check_bit("ack_async_clear", o_wb_ack, 1'b0);
        check_bit("irq_async_clear", o_timer_irq, 1'b0);
        check_word("rdt_async_clear", o_wb_rdt, 32'h0);
        @(negedge i_clk);
        i_wb_stb = 1'b0;
        i_rst_n  = 1'b1;
        @(negedge i_clk);
        rd_chk(3'd4, 32'h0,         "ctrl_after_reset");
        rd_chk(3'd2, 32'hFFFF_FFFF, "cmp_lo_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
